// File: rtl/mem_arbiter_pkg.sv
// Shared memory-op encodings and the grant pick rule for the two-master memory arbiter.
// The op encodings match the CPU's load/store field values, so ops pass through the arbiter unchanged.
package mem_arbiter_pkg;

    typedef logic [2:0] read_op_t;
    typedef logic [1:0] write_op_t;

    localparam read_op_t LB    = 3'b000;
    localparam read_op_t LH    = 3'b001;
    localparam read_op_t LW    = 3'b010;
    localparam read_op_t LNONE = 3'b011;
    localparam read_op_t LBU   = 3'b100;
    localparam read_op_t LHU   = 3'b101;

    localparam write_op_t SB    = 2'b00;
    localparam write_op_t SH    = 2'b01;
    localparam write_op_t SW    = 2'b10;
    localparam write_op_t SNONE = 2'b11;

    // Returns the winning master index (0 = m0, 1 = m1); only meaningful when a request is present.
    function automatic logic pick_master(input logic req0, input logic req1,
                                         input logic last_owner, input logic round_robin);
        if (req0 && req1)
            return round_robin ? ~last_owner : 1'b0;
        return req1 & ~req0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's memory-op channel; the arbiter sits on the slave side of each channel.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    read_op_t              read_op;
    write_op_t             write_op;
    logic [31:0]           wdata;
    logic                  ack;
    logic [31:0]           rdata;

    modport master (output req, addr, read_op, write_op, wdata, input  ack, rdata);
    modport slave  (input  req, addr, read_op, write_op, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between the CPU (m0) and the debug/loader master (m1).
// One transaction at a time: IDLE (grant) -> ISSUE (drive RAM) -> WAIT (latency) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LATENCY     = 1,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_arbiter_if.slave          m0,
    mem_arbiter_if.slave          m1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output read_op_t              mem_read_op,
    output write_op_t             mem_write_op,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("mem_arbiter: LATENCY must be in 1..4");
    end

    localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                state;
    logic [1:0]            count;
    logic                  ack0;
    logic                  ack1;
    logic                  any_req;
    logic                  pick;
    logic [ADDR_WIDTH-1:0] sel_addr;
    read_op_t              sel_read_op;
    write_op_t             sel_write_op;
    logic [31:0]           sel_wdata;

    assign any_req      = m0.req | m1.req;
    assign pick         = pick_master(m0.req, m1.req, owner, ROUND_ROBIN != 0);
    assign sel_addr     = pick ? m1.addr     : m0.addr;
    assign sel_read_op  = pick ? m1.read_op  : m0.read_op;
    assign sel_write_op = pick ? m1.write_op : m0.write_op;
    assign sel_wdata    = pick ? m1.wdata    : m0.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 2'd0;
            busy         <= 1'b0;
            owner        <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            mem_addr     <= '0;
            mem_read_op  <= LNONE;
            mem_write_op <= SNONE;
            mem_wdata    <= 32'h0;
        end else begin
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            mem_addr     <= '0;
            mem_read_op  <= LNONE;
            mem_write_op <= SNONE;
            mem_wdata    <= 32'h0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= ISSUE;
                        owner        <= pick;
                        busy         <= 1'b1;
                        count        <= CNT_LOAD;
                        mem_addr     <= sel_addr;
                        mem_wdata    <= sel_wdata;
                        mem_write_op <= sel_write_op;
                        // A store suppresses any read the master also presented.
                        mem_read_op  <= (sel_write_op != SNONE) ? LNONE : sel_read_op;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    if (CNT_LOAD == 2'd0) begin
                        ack0 <= ~owner;
                        ack1 <= owner;
                    end
                end
                WAIT: begin
                    if (count == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 2'd1;
                        // Ack lands in the WAIT cycle whose count reads zero.
                        if (count == 2'd1) begin
                            ack0 <= ~owner;
                            ack1 <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.rdata = ack0 ? mem_rdata : 32'h0;
    assign m1.rdata = ack1 ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT1/RR, LAT3/RR, LAT1/fixed) each with a behavioural RAM,
// checked against a transaction-timeline reference model under directed and random traffic.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int MAXC = 64;

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int rr_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic logic [31:0] ram_init(input int i);
        return 32'hC0DE_0000 + 32'(i * 4);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic        ram_clear;
    logic [2:0]  req0_v, req1_v;
    logic [31:0] addr0 [3];
    logic [31:0] addr1 [3];
    read_op_t    rop0 [3];
    read_op_t    rop1 [3];
    write_op_t   wop0 [3];
    write_op_t   wop1 [3];
    logic [31:0] wd0 [3];
    logic [31:0] wd1 [3];

    logic [2:0]  ack0_v, ack1_v, busy_v, own_v;
    logic [31:0] rd0_s [3];
    logic [31:0] rd1_s [3];
    logic [31:0] maddr_s [3];
    logic [31:0] mwd_s [3];
    read_op_t    mrop_s [3];
    write_op_t   mwop_s [3];

    for (genvar k = 0; k < 3; k++) begin : g
        mem_arbiter_if #(.ADDR_WIDTH(AW)) m0_bus ();
        mem_arbiter_if #(.ADDR_WIDTH(AW)) m1_bus ();
        logic [31:0] mem_addr;
        read_op_t    mem_read_op;
        write_op_t   mem_write_op;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        busy;
        logic        owner;
        logic [31:0] ram [64];
        logic [31:0] pipe [4];

        assign m0_bus.req      = req0_v[k];
        assign m0_bus.addr     = addr0[k];
        assign m0_bus.read_op  = rop0[k];
        assign m0_bus.write_op = wop0[k];
        assign m0_bus.wdata    = wd0[k];
        assign m1_bus.req      = req1_v[k];
        assign m1_bus.addr     = addr1[k];
        assign m1_bus.read_op  = rop1[k];
        assign m1_bus.write_op = wop1[k];
        assign m1_bus.wdata    = wd1[k];

        mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(lat_of(k)), .ROUND_ROBIN(rr_of(k))) dut (
            .clk          (clk),
            .reset        (rst_v[k]),
            .m0           (m0_bus),
            .m1           (m1_bus),
            .mem_addr     (mem_addr),
            .mem_read_op  (mem_read_op),
            .mem_write_op (mem_write_op),
            .mem_wdata    (mem_wdata),
            .mem_rdata    (mem_rdata),
            .busy         (busy),
            .owner        (owner)
        );

        // Word RAM: write at issue, read data appears LATENCY cycles after issue (0 if no read issued).
        always_ff @(posedge clk) begin
            if (ram_clear) begin
                for (int i = 0; i < 64; i++) ram[i] <= ram_init(i);
            end else if (mem_write_op != SNONE) begin
                ram[mem_addr[7:2]] <= mem_wdata;
            end
            pipe[0] <= (mem_read_op != LNONE) ? ram[mem_addr[7:2]] : 32'h0;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata = pipe[lat_of(k) - 1];

        assign ack0_v[k]  = m0_bus.ack;
        assign ack1_v[k]  = m1_bus.ack;
        assign rd0_s[k]   = m0_bus.rdata;
        assign rd1_s[k]   = m1_bus.rdata;
        assign busy_v[k]  = busy;
        assign own_v[k]   = owner;
        assign maddr_s[k] = mem_addr;
        assign mwd_s[k]   = mem_wdata;
        assign mrop_s[k]  = mem_read_op;
        assign mwop_s[k]  = mem_write_op;
    end

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] mdl_mem [3][64];
    int          mdl_owner [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: walks a cycle timeline. The port is free at t_free; a grant at cycle c
    // issues at c+1, acks at c+1+LAT and frees the port at c+2+LAT.
    task automatic run(input int k, input int n,
                       input int stop0, input bit hold0, input logic [31:0] a0,
                       input read_op_t r0, input write_op_t w0, input logic [31:0] d0,
                       input int stop1, input bit hold1, input logic [31:0] a1,
                       input read_op_t r1, input write_op_t w1, input logic [31:0] d1);
        int          lat = lat_of(k);
        int          len = n + lat + 3;
        int          t_free = 0;
        int          own = mdl_owner[k];
        bit          got0 = 0, got1 = 0;
        int          ackc0 = 0, ackc1 = 0;
        bit          e_req0 [MAXC], e_req1 [MAXC], e_ack0 [MAXC], e_ack1 [MAXC];
        bit          e_busy [MAXC], e_iss [MAXC];
        int          e_own [MAXC];
        logic [31:0] e_rd0 [MAXC], e_rd1 [MAXC], e_addr [MAXC], e_wd [MAXC];
        read_op_t    e_rop [MAXC];
        write_op_t   e_wop [MAXC];
        string       tg;

        for (int c = 0; c < MAXC; c++) begin
            e_req0[c] = 0; e_req1[c] = 0; e_ack0[c] = 0; e_ack1[c] = 0;
            e_busy[c] = 0; e_iss[c] = 0;  e_own[c] = 0;
            e_rd0[c] = 0;  e_rd1[c] = 0;  e_addr[c] = 0; e_wd[c] = 0;
            e_rop[c] = LNONE; e_wop[c] = SNONE;
        end

        for (int c = 0; c < len; c++) begin
            e_own[c]  = own;
            e_req0[c] = (c < n) && (c < stop0) && (hold0 || !(got0 && c > ackc0));
            e_req1[c] = (c < n) && (c < stop1) && (hold1 || !(got1 && c > ackc1));
            if (c == t_free) begin
                if (e_req0[c] || e_req1[c]) begin
                    int          w, iss, a;
                    logic [31:0] ad, rd;
                    read_op_t    ro;
                    write_op_t   wo;
                    if (e_req0[c] && e_req1[c]) w = (rr_of(k) != 0) ? 1 - own : 0;
                    else                        w = e_req1[c] ? 1 : 0;
                    own = w;
                    iss = c + 1;
                    a   = c + 1 + lat;
                    ad  = (w == 1) ? a1 : a0;
                    wo  = (w == 1) ? w1 : w0;
                    ro  = (w == 1) ? r1 : r0;
                    e_iss[iss]  = 1;
                    e_addr[iss] = ad;
                    e_wd[iss]   = (w == 1) ? d1 : d0;
                    e_wop[iss]  = wo;
                    e_rop[iss]  = (wo != SNONE) ? LNONE : ro;
                    for (int j = iss; j <= a; j++) e_busy[j] = 1;
                    rd = 32'h0;
                    if (wo != SNONE)      mdl_mem[k][ad[7:2]] = e_wd[iss];
                    else if (ro != LNONE) rd = mdl_mem[k][ad[7:2]];
                    if (w == 0) begin e_ack0[a] = 1; e_rd0[a] = rd; got0 = 1; ackc0 = a; end
                    else        begin e_ack1[a] = 1; e_rd1[a] = rd; got1 = 1; ackc1 = a; end
                    t_free = a + 1;
                end else begin
                    t_free = c + 1;
                end
            end
        end
        mdl_owner[k] = own;

        addr0[k] = a0; rop0[k] = r0; wop0[k] = w0; wd0[k] = d0;
        addr1[k] = a1; rop1[k] = r1; wop1[k] = w1; wd1[k] = d1;
        for (int c = 0; c < len; c++) begin
            req0_v[k] = e_req0[c];
            req1_v[k] = e_req1[c];
            tg = $sformatf("k%0d c%0d", k, c);
            chk({tg, " ack0"},  32'(ack0_v[k]), 32'(e_ack0[c]));
            chk({tg, " ack1"},  32'(ack1_v[k]), 32'(e_ack1[c]));
            chk({tg, " rdata0"}, rd0_s[k], e_rd0[c]);
            chk({tg, " rdata1"}, rd1_s[k], e_rd1[c]);
            chk({tg, " busy"},  32'(busy_v[k]), 32'(e_busy[c]));
            chk({tg, " owner"}, 32'(own_v[k]), 32'(e_own[c]));
            chk({tg, " mem_read_op"},  32'(mrop_s[k]), 32'(e_rop[c]));
            chk({tg, " mem_write_op"}, 32'(mwop_s[k]), 32'(e_wop[c]));
            if (e_iss[c] || !e_busy[c]) begin
                chk({tg, " mem_addr"},  maddr_s[k], e_addr[c]);
                chk({tg, " mem_wdata"}, mwd_s[k], e_wd[c]);
            end
            step();
        end
        req0_v[k] = 1'b0;
        req1_v[k] = 1'b0;
    endtask

    function automatic read_op_t rand_rop();
        case ($urandom_range(0, 5))
            0: return LB;
            1: return LH;
            2: return LW;
            3: return LBU;
            4: return LHU;
            default: return LNONE;
        endcase
    endfunction

    function automatic write_op_t rand_wop();
        case ($urandom_range(0, 5))
            0: return SB;
            1: return SH;
            2: return SW;
            default: return SNONE;
        endcase
    endfunction

    initial begin
        rst_v     = 3'b111;
        ram_clear = 1'b1;
        req0_v    = 3'b000;
        req1_v    = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr0[k] = 0; addr1[k] = 0; wd0[k] = 0; wd1[k] = 0;
            rop0[k] = LNONE; rop1[k] = LNONE; wop0[k] = SNONE; wop1[k] = SNONE;
            mdl_owner[k] = 1;
            for (int i = 0; i < 64; i++) mdl_mem[k][i] = ram_init(i);
        end
        step(); step(); step();

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset k%0d busy", k),  32'(busy_v[k]), 32'd0);
            chk($sformatf("reset k%0d owner", k), 32'(own_v[k]),  32'd1);
            chk($sformatf("reset k%0d acks", k),  32'({ack1_v[k], ack0_v[k]}), 32'd0);
            chk($sformatf("reset k%0d rop", k),   32'(mrop_s[k]), 32'(LNONE));
            chk($sformatf("reset k%0d wop", k),   32'(mwop_s[k]), 32'(SNONE));
            chk($sformatf("reset k%0d addr", k),  maddr_s[k], 32'h0);
        end
        rst_v     = 3'b000;
        ram_clear = 1'b0;
        step();

        // Preload 0x10, then m0 LW 0x10 (LAT 1).
        run(0, 6, 0, 0, 0, LNONE, SNONE, 0, 6, 0, 32'h10, LNONE, SW, 32'hDEADBEEF);
        run(0, 6, 6, 0, 32'h10, LW, SNONE, 0, 0, 0, 0, LNONE, SNONE, 0);
        // Continuous contention, round robin.
        run(0, 12, 12, 1, 32'h10, LW, SNONE, 0, 12, 1, 32'h14, LW, SNONE, 0);
        // Fixed priority: m1 only after m0 drops.
        run(2, 14, 9, 1, 32'h8, LW, SNONE, 0, 14, 1, 32'hC, LH, SNONE, 0);
        // Store wins over a simultaneous read, then read back.
        run(0, 6, 0, 0, 0, LNONE, SNONE, 0, 6, 0, 32'h20, LW, SW, 32'h12345678);
        run(0, 6, 6, 0, 32'h20, LW, SNONE, 0, 0, 0, 0, LNONE, SNONE, 0);
        // LAT 3: normal LBU, then req dropped during WAIT.
        run(1, 6, 6, 0, 32'h10, LBU, SNONE, 0, 0, 0, 0, LNONE, SNONE, 0);
        run(1, 6, 2, 0, 32'h14, LBU, SNONE, 0, 0, 0, 0, LNONE, SNONE, 0);
        // No-op request still acks.
        run(0, 6, 6, 0, 32'h4, LNONE, SNONE, 0, 0, 0, 0, LNONE, SNONE, 0);

        // Reset during WAIT on the LAT 3 instance: no ack, idle outputs, owner back to 1.
        addr0[1] = 32'h18; rop0[1] = LW; wop0[1] = SNONE; wd0[1] = 0;
        req0_v[1] = 1'b1;
        step(); step();
        rst_v[1]  = 1'b1;
        req0_v[1] = 1'b0;
        step();
        chk("rst_wait busy",  32'(busy_v[1]), 32'd0);
        chk("rst_wait ack0",  32'(ack0_v[1]), 32'd0);
        chk("rst_wait rop",   32'(mrop_s[1]), 32'(LNONE));
        chk("rst_wait wop",   32'(mwop_s[1]), 32'(SNONE));
        chk("rst_wait owner", 32'(own_v[1]),  32'd1);
        rst_v[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst_wait noack%0d", i), 32'({ack1_v[1], ack0_v[1]}), 32'd0);
        end
        mdl_owner[1] = 1;
        run(1, 12, 12, 0, 32'h1C, LW, SNONE, 0, 12, 0, 32'h24, LHU, SNONE, 0);

        // Random traffic on all three instances.
        for (int it = 0; it < 36; it++) begin
            int          k  = it % 3;
            int          n  = int'($urandom_range(6, 30));
            bit          h0 = ($urandom_range(0, 3) == 0);
            bit          h1 = ($urandom_range(0, 3) == 0);
            int          s0 = ($urandom_range(0, 4) == 0) ? 0 : (h0 ? int'($urandom_range(2, 30)) : n);
            int          s1 = ($urandom_range(0, 4) == 0) ? 0 : (h1 ? int'($urandom_range(2, 30)) : n);
            logic [31:0] ra0 = 32'($urandom_range(0, 63)) << 2;
            logic [31:0] ra1 = 32'($urandom_range(0, 63)) << 2;
            run(k, n, s0, h0, ra0, rand_rop(), rand_wop(), $urandom(),
                      s1, h1, ra1, rand_rop(), rand_wop(), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
